// File: rtl/cic_pkg.sv
// cic_pkg: shared FSM state type and counter-width helper for the sequenced CIC comb
package cic_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic int clog2_l(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/cic_comb_dly_mem.sv
// cic_comb_dly_mem: per-stage differential-delay lines, one stage shifted per cycle by index
module cic_comb_dly_mem #(
  parameter int DW = 48,
  parameter int N  = 7,
  parameter int M  = 1,
  parameter int KW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en_i,
  input  logic [KW-1:0]        k_i,
  input  logic signed [DW-1:0] wr_data_i,
  output logic signed [DW-1:0] rd_data_o
);
  logic signed [DW-1:0] mem_q [N][M];
  // Oldest word of the addressed stage feeds the shared subtractor
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < N; i++) rd_data_o = k_i == KW'(i) ? mem_q[i][M-1] : rd_data_o;
  end
  // Only the addressed stage shifts; the new word enters at tap 0
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        if (rst) mem_q[i][j] <= '0;
        else if (shift_en_i && k_i == KW'(i)) mem_q[i][j] <= j == 0 ? wr_data_i : mem_q[i][j == 0 ? 0 : j-1];
endmodule

// File: rtl/cic_comb_seq.sv
// cic_comb_seq: time-multiplexed CIC comb chain sharing one subtractor across all stages
module cic_comb_seq
  import cic_pkg::*;
#(
  parameter int DW     = 48,
  parameter int OUT_DW = 18,
  parameter int CIC_N  = 7,
  parameter int CIC_M  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DW-1:0]     inp_samp_data,
  input  logic                     inp_samp_str,
  input  logic                     ovr_clr,
  output logic signed [OUT_DW-1:0] out_samp_data,
  output logic                     out_samp_str,
  output logic                     busy,
  output logic                     overrun
);
  localparam int KW = clog2_l(CIC_N);
  state_e state_q;
  logic [KW-1:0] k_q;
  logic signed [DW-1:0] x_q, dly_rd, diff_d;
  logic signed [OUT_DW-1:0] out_q;
  logic str_q, busy_q, ovr_q, run, last;
  assign run = state_q == RUN;
  assign last = k_q == KW'(CIC_N - 1);
  assign diff_d = x_q - dly_rd;
  cic_comb_dly_mem #(.DW(DW), .N(CIC_N), .M(CIC_M), .KW(KW)) u_dly (
    .clk       (clk),
    .rst       (reset),
    .shift_en_i(run),
    .k_i       (k_q),
    .wr_data_i (x_q),
    .rd_data_o (dly_rd)
  );
  // Sequencer: capture a sample, walk k through every stage, emit the last difference
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      out_q   <= '0;
      str_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      str_q <= 1'b0;
      ovr_q <= (inp_samp_str & busy_q) | (ovr_q & ~ovr_clr);
      if (state_q == IDLE) begin
        if (inp_samp_str) begin
          x_q     <= inp_samp_data;
          k_q     <= '0;
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
      end else begin
        x_q <= diff_d;
        k_q <= last ? '0 : k_q + KW'(1);
        if (last) begin
          out_q   <= diff_d[DW-1 -: OUT_DW];
          str_q   <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  assign out_samp_data = out_q;
  assign out_samp_str  = str_q;
  assign busy          = busy_q;
  assign overrun       = ovr_q;
endmodule

// File: tb/tb_cic_comb_seq.sv
// tb_cic_comb_seq: directed and random checks of three cic_comb_seq configurations against a binomial-sum model
module tb_cic_comb_seq;
  localparam int PN   [3] = '{3, 1, 7};
  localparam int PM   [3] = '{1, 2, 1};
  localparam int PDW  [3] = '{16, 8, 48};
  localparam int PODW [3] = '{16, 8, 18};

  logic clk = 1'b0;
  logic rst;
  logic str [3], clr [3], o_str [3], o_busy [3], o_ovr [3];
  longint dat [3];
  logic signed [63:0] o_v [3];
  logic signed [15:0] out0;
  logic signed [7:0]  out1;
  logic signed [17:0] out2;

  int cyc, n_vec, n_bad;
  longint hist [3][2048];
  int hcnt [3], free_at [3], blo [3], bhi [3], due [3];
  bit pend [3], ovr_m [3];
  longint pend_v [3], last_v [3];
  longint wl [5] = '{127, -128, -128, 127, 0};

  always #5 clk = ~clk;

  cic_comb_seq #(.DW(16), .OUT_DW(16), .CIC_N(3), .CIC_M(1)) u0 (
    .clk(clk), .reset(rst), .inp_samp_data(dat[0][15:0]), .inp_samp_str(str[0]), .ovr_clr(clr[0]),
    .out_samp_data(out0), .out_samp_str(o_str[0]), .busy(o_busy[0]), .overrun(o_ovr[0]));
  cic_comb_seq #(.DW(8), .OUT_DW(8), .CIC_N(1), .CIC_M(2)) u1 (
    .clk(clk), .reset(rst), .inp_samp_data(dat[1][7:0]), .inp_samp_str(str[1]), .ovr_clr(clr[1]),
    .out_samp_data(out1), .out_samp_str(o_str[1]), .busy(o_busy[1]), .overrun(o_ovr[1]));
  cic_comb_seq #(.DW(48), .OUT_DW(18), .CIC_N(7), .CIC_M(1)) u2 (
    .clk(clk), .reset(rst), .inp_samp_data(dat[2][47:0]), .inp_samp_str(str[2]), .ovr_clr(clr[2]),
    .out_samp_data(out2), .out_samp_str(o_str[2]), .busy(o_busy[2]), .overrun(o_ovr[2]));

  assign o_v[0] = 64'(out0);
  assign o_v[1] = 64'(out1);
  assign o_v[2] = 64'(out2);

  function automatic longint sx(longint v, int w);
    return (v << (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint binom(int n, int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint rnd();
    return longint'({$urandom, $urandom});
  endfunction

  // y[n] = sum_j (-1)^j C(N,j) x[n - j*M], modulo 2^DW, top OUT_DW bits
  function automatic longint ref_out(int i);
    longint y = 0;
    int n = hcnt[i] - 1;
    for (int j = 0; j <= PN[i]; j++)
      if (n - j * PM[i] >= 0) y += (j % 2 == 1 ? -1 : 1) * binom(PN[i], j) * hist[i][n - j * PM[i]];
    return sx(y, PDW[i]) >>> (PDW[i] - PODW[i]);
  endfunction

  task automatic chk(string tag, logic signed [63:0] act, logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic model(int i);
    bit rej;
    if (rst) begin
      pend[i] = 0; hcnt[i] = 0; free_at[i] = 0; blo[i] = 0; bhi[i] = -1; ovr_m[i] = 0; last_v[i] = 0;
      return;
    end
    rej = str[i] && cyc < free_at[i];
    if (str[i] && !rej) begin
      hist[i][hcnt[i]] = sx(dat[i], PDW[i]);
      hcnt[i]++;
      pend[i] = 1;
      pend_v[i] = ref_out(i);
      due[i] = cyc + PN[i] + 1;
      free_at[i] = due[i];
      blo[i] = cyc + 1;
      bhi[i] = cyc + PN[i];
    end
    ovr_m[i] = rej || (ovr_m[i] && !clr[i]);
  endtask

  task automatic check(int i);
    bit es = pend[i] && due[i] == cyc;
    if (es) begin
      last_v[i] = pend_v[i];
      pend[i] = 0;
    end
    chk($sformatf("u%0d.str", i), 64'(o_str[i]), 64'(es));
    chk($sformatf("u%0d.data", i), o_v[i], last_v[i]);
    chk($sformatf("u%0d.busy", i), 64'(o_busy[i]), 64'(cyc >= blo[i] && cyc <= bhi[i]));
    chk($sformatf("u%0d.ovr", i), 64'(o_ovr[i]), 64'(ovr_m[i]));
  endtask

  task automatic step();
    for (int i = 0; i < 3; i++) model(i);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) check(i);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      str[i] = 0;
      clr[i] = 0;
    end
  endtask

  initial begin
    rst = 1;
    for (int i = 0; i < 3; i++) dat[i] = 0;
    idle_all();
    repeat (3) step();
    rst = 0;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 3; i++) begin
        str[i] = 1;
        dat[i] = i == 2 ? rnd() : longint'(n == 0);
      end
      step();
      idle_all();
      repeat (7) step();
    end
    rst = 1;
    step();
    rst = 0;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 3; i++) str[i] = 1;
      dat[0] = 5;
      dat[1] = wl[n];
      dat[2] = rnd();
      step();
      idle_all();
      repeat (7) step();
    end
    str[0] = 1; dat[0] = 9; step();
    str[0] = 0; step();
    str[0] = 1; dat[0] = 77; step();
    str[0] = 0; step();
    str[0] = 1; dat[0] = 3; step();
    str[0] = 0; clr[0] = 1; step();
    str[0] = 1; dat[0] = 55; step();
    idle_all(); repeat (3) step();
    clr[0] = 1; step();
    idle_all(); repeat (4) step();
    str[0] = 1; dat[0] = -7; step();
    str[0] = 0; step();
    rst = 1; step();
    rst = 0; repeat (6) step();
    for (int n = 0; n < 5; n++) begin
      str[0] = 1;
      dat[0] = longint'(n == 0);
      step();
      str[0] = 0;
      repeat (7) step();
    end
    for (int c = 0; c < 1500; c++) begin
      rst = $urandom_range(0, 299) == 0;
      for (int i = 0; i < 3; i++) begin
        str[i] = $urandom_range(0, 2) == 0;
        dat[i] = rnd();
        clr[i] = $urandom_range(0, 15) == 0;
      end
      step();
    end
    rst = 0;
    idle_all();
    repeat (10) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
